offchip_mem_model_mc: RTL
=========================

Name: offchip_mem_model_mc

Overview:
- Parametrised, multi-channel model of the off-chip memory slave that HLS-generated accelerators see on their Mout_*/M_* master bus.
- Generalises the fixed 2-channel, fixed-latency (read 2 / write 1) in-testbench memory to:
  - N channels;
  - configurable data width, address width and window size;
  - independent read and write latencies.
- Adds a byte loader port, protocol-error reporting and defined multi-channel collision rules.
- Instantiated by simulation top-levels between the accelerator master ports and the bench stimulus loader.

Parameters:
- N_CH, 2, number of independent memory channels
- DATA_W, 32, data bits per channel; multiple of 8
- ADDR_W, 12, byte-address bits per channel
- SIZE_W, 6, access-size field bits per channel; access size is in bits
- MEM_BYTES, 4096, bytes of backing store
- BASE_ADDR, 0, first byte address of the window
- RD_LAT, 2, read latency in cycles, >=1
- WR_LAT, 1, write latency in cycles, >=1

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- oe_ram  in  N_CH  per-channel read request, held until data_rdy
- we_ram  in  N_CH  per-channel write request, held until data_rdy
- addr_ram  in  N_CH*ADDR_W  per-channel byte address
- wdata_ram  in  N_CH*DATA_W  per-channel write data
- data_ram_size  in  N_CH*SIZE_W  per-channel access size in bits
- rdata_ram  out  N_CH*DATA_W  per-channel read data
- data_rdy  out  N_CH  per-channel completion strobe
- init_we  in  1  loader byte write
- init_addr  in  ADDR_W  loader byte address, window-relative
- init_data  in  8  loader byte
- err_both  out  N_CH  sticky: oe and we asserted together on the channel

Behaviour:
- Window hit: BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES. Accesses outside the window are ignored: data_rdy 0, rdata 0, no write, counter held at 0.
- Word access: covers bytes addr..addr+DATA_W/8-1, little-endian.
- Size mask: mask = (1<<size)-1, saturating to all-ones when size >= DATA_W. Size 0 gives a no-op write but still completes.
- Per-channel latency counter cnt, range 0..LAT-1:
  - Increments each cycle the request is held in-window.
  - data_rdy asserts combinationally when cnt==LAT-1; cnt returns to 0 on the following edge.
  - A request still held after data_rdy starts a new access (back-to-back, no bubble).
  - Deasserting a request before data_rdy aborts it: cnt returns to 0, no write.
- Read:
  - Data is sampled at the request's first cycle (cnt==0).
  - If RD_LAT>=2, the sample is held in a per-channel register and presented on rdata only in the data_rdy cycle; rdata is 0 otherwise.
  - If RD_LAT==1, rdata is a combinational read in the same cycle.
- Write: commits on the clock edge that ends the data_rdy cycle, as new = (wdata & mask) | (old & ~mask).
- Ordering within one edge:
  - Reads sample pre-edge contents (read-before-write).
  - Simultaneous writes to overlapping bytes: the higher channel index wins, byte-wise.
  - The loader port commits before channel writes on the same edge.
- Word straddling window end: bytes beyond MEM_BYTES read as 0 and are dropped on write.
- Protocol error: oe&we on a channel sets err_both[ch] (sticky). The access is treated as a read; no write occurs.
- Reset (asynchronous):
  - Clears cnt, read holding registers and err_both.
  - data_rdy=0 and rdata=0 immediately.
  - Backing store is not reset.
  - Reset mid-access drops the access, with no partial write.
- Loader writes do not interact with the channel counters.

Optional Feature:
- Macro: MEM_MODEL_STATS_EN.
- When defined, the block adds three outputs:
  - rd_count (N_CH*32): completed reads per channel;
  - wr_count (N_CH*32): completed writes per channel;
  - busy_cycles (N_CH*32): cycles with an in-window request pending.
- All three are cleared by reset and wrap modulo 2^32.
- When not defined, these ports and their counters are absent and behaviour is otherwise identical.

Test Plan:
- Load bytes 0x11,0x22,0x33,0x44 at offset 0; ch0 read addr BASE+0, size 32, RD_LAT=2 -> data_rdy[0] in 2nd cycle, rdata ch0 = 0x44332211, rdata 0 in 1st cycle.
- ch1 write 0xAABBCCDD, size 8, to a word holding 0x44332211 -> data_rdy[1] in request cycle (WR_LAT=1); later read returns 0x443322DD.
- ch0 and ch1 write 0x01 and 0x02 to the same address on the same cycle -> stored value 0x02; ch0 read plus ch1 write of the same word on the same cycle -> read returns old data.
- Request held 3 consecutive reads with RD_LAT=2 -> data_rdy pulses on cycles 2, 4, 6; address outside the window -> data_rdy stays 0 for 10 cycles.
- Assert oe and we on ch0 -> err_both[0]=1, memory unchanged; reset -> err_both=0, data_rdy=0 immediately; memory contents retained.
- Reset asserted in cycle 1 of a WR_LAT=3 write -> no write committed; with MEM_MODEL_STATS_EN, wr_count unchanged and rd_count increments by exactly 1 per data_rdy read.

Source files
------------

// File: rtl/offchip_mem_model_mc.sv
// Multi-channel off-chip memory slave model with per-channel latency counters and a byte loader.
// Define MEM_MODEL_STATS_EN to add per-channel rd_count/wr_count/busy_cycles outputs.
module offchip_mem_model_mc #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned SIZE_W    = 6,
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_LAT    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          oe_ram,
    input  logic [N_CH-1:0]          we_ram,
    input  logic [N_CH*ADDR_W-1:0]   addr_ram,
    input  logic [N_CH*DATA_W-1:0]   wdata_ram,
    input  logic [N_CH*SIZE_W-1:0]   data_ram_size,
    output logic [N_CH*DATA_W-1:0]   rdata_ram,
    output logic [N_CH-1:0]          data_rdy,
    input  logic                     init_we,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic [7:0]               init_data,
    output logic [N_CH-1:0]          err_both
`ifdef MEM_MODEL_STATS_EN
    ,
    output logic [N_CH*32-1:0]       rd_count,
    output logic [N_CH*32-1:0]       wr_count,
    output logic [N_CH*32-1:0]       busy_cycles
`endif
);

    localparam int unsigned BYTES_W = DATA_W / 8;
    localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int unsigned MEM_AW  = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0] mem_q [MEM_BYTES];

    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0][DATA_W-1:0] hold_q, hold_d;
    logic [N_CH-1:0]             err_q, err_d;

    logic [N_CH-1:0]             active, rdy, do_wr;
    logic [N_CH-1:0][DATA_W-1:0] mask, rd_word;
    logic [N_CH-1:0][BYTES_W-1:0][MEM_AW-1:0] wr_idx;
    logic [N_CH-1:0][BYTES_W-1:0][7:0]        wr_byte;
    logic [N_CH-1:0][BYTES_W-1:0]             wr_en;

    always_comb begin
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        err_d     = err_q;
        active    = '0;
        rdy       = '0;
        do_wr     = '0;
        mask      = '0;
        rd_word   = '0;
        wr_idx    = '0;
        wr_byte   = '0;
        wr_en     = '0;
        rdata_ram = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            logic [31:0]       a, off, idx;
            logic [SIZE_W-1:0] sz;
            int unsigned       lat;
            a   = 32'(addr_ram[ch*ADDR_W +: ADDR_W]);
            off = a - BASE_ADDR;
            sz  = data_ram_size[ch*SIZE_W +: SIZE_W];
            lat = oe_ram[ch] ? RD_LAT : WR_LAT;

            active[ch] = (oe_ram[ch] | we_ram[ch]) & (a >= BASE_ADDR) & (off < MEM_BYTES);
            rdy[ch]    = active[ch] & ~reset & (cnt_q[ch] == CNT_W'(lat - 1));
            // oe&we together is a protocol error and is served as a read
            do_wr[ch]  = rdy[ch] & we_ram[ch] & ~oe_ram[ch];
            cnt_d[ch]  = (active[ch] & ~rdy[ch]) ? cnt_q[ch] + CNT_W'(1) : '0;
            err_d[ch]  = err_q[ch] | (oe_ram[ch] & we_ram[ch]);
            mask[ch]   = (32'(sz) >= DATA_W) ? '1 : (DATA_W'(1) << sz) - DATA_W'(1);

            for (int b = 0; b < BYTES_W; b++) begin
                logic [7:0] old_b, m_b;
                idx = off + 32'(b);
                if (idx < MEM_BYTES) begin
                    rd_word[ch][8*b +: 8] = mem_q[MEM_AW'(idx)];
                end
                // Loader commits first, so a partial channel write merges with its byte
                old_b = (init_we && 32'(init_addr) == idx) ? init_data : rd_word[ch][8*b +: 8];
                m_b   = mask[ch][8*b +: 8];
                wr_idx[ch][b]  = MEM_AW'(idx);
                wr_byte[ch][b] = (wdata_ram[ch*DATA_W + 8*b +: 8] & m_b) | (old_b & ~m_b);
                wr_en[ch][b]   = do_wr[ch] & (idx < MEM_BYTES) & (m_b != 8'h00);
            end

            if (active[ch] & oe_ram[ch] & (cnt_q[ch] == '0)) begin
                hold_d[ch] = rd_word[ch];
            end
            if (rdy[ch] & oe_ram[ch]) begin
                rdata_ram[ch*DATA_W +: DATA_W] = (RD_LAT >= 2) ? hold_q[ch] : rd_word[ch];
            end
        end
    end

    assign data_rdy = rdy;
    assign err_both = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            hold_q <= '0;
            err_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            err_q  <= err_d;
        end
    end

    // Backing store is deliberately not reset; later channels overwrite earlier ones
    always_ff @(posedge clock) begin
        if (init_we && (32'(init_addr) < MEM_BYTES)) begin
            mem_q[MEM_AW'(init_addr)] <= init_data;
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int b = 0; b < BYTES_W; b++) begin
                if (wr_en[ch][b]) begin
                    mem_q[wr_idx[ch][b]] <= wr_byte[ch][b];
                end
            end
        end
    end

`ifdef MEM_MODEL_STATS_EN
    logic [N_CH-1:0][31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, busy_q, busy_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        busy_d   = busy_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            rd_cnt_d[ch] = rd_cnt_q[ch] + 32'(rdy[ch] & oe_ram[ch]);
            wr_cnt_d[ch] = wr_cnt_q[ch] + 32'(do_wr[ch]);
            busy_d[ch]   = busy_q[ch] + 32'(active[ch]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            busy_q   <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign busy_cycles = busy_q;
`endif

endmodule
